// File: rtl/pcs_sync_pkg.sv
// Shared definitions for the 1000BASE-X code-group synchronization lanes:
// state encoding, comma patterns and code-group classification helpers.
package pcs_sync_pkg;

  typedef logic [1:0] sync_state_t;

  localparam sync_state_t StLossOfSync   = 2'd0;
  localparam sync_state_t StCommaDetect  = 2'd1;
  localparam sync_state_t StAcquireSync  = 2'd2;
  localparam sync_state_t StSyncAcquired = 2'd3;

  // Seven-bit comma prefixes of K28.1/K28.5/K28.7 in both disparities.
  localparam logic [6:0] CommaPlus  = 7'b0011111;
  localparam logic [6:0] CommaMinus = 7'b1100000;

  // Width of the comma/good/bad counters; thresholds are limited to 7.
  localparam int unsigned SmallCntW = 3;

  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == CommaPlus) || (cg[9:3] == CommaMinus);
  endfunction

  function automatic logic is_invalid(input logic [9:0] cg);
    logic [3:0] ones;
    ones = 4'($countones(cg));
    return (ones < 4'd4) || (ones > 4'd6);
  endfunction

endpackage

// File: rtl/pcs_sync_lane.sv
// One lane of code-group synchronization: sync FSM, acquisition/loss counters,
// saturating loss-of-sync counter and the registered SUDI output.
module pcs_sync_lane
  import pcs_sync_pkg::*;
#(
  parameter int unsigned COMMA_ACQ = 3,
  parameter int unsigned GOOD_CGS  = 3,
  parameter int unsigned MAX_BAD   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             power_on,
  input  logic             signal_detect,
  input  logic             indicate,
  input  logic [9:0]       pudi,
  output logic             code_sync_status,
  output logic [10:0]      sudi,
  output logic [CNT_W-1:0] sync_loss_cnt
);

  sync_state_t          state_q, state_d;
  logic                 rx_even_q, rx_even_d;
  logic [SmallCntW-1:0] comma_cnt_q, comma_cnt_d;
  logic [SmallCntW-1:0] bad_cnt_q, bad_cnt_d;
  logic [SmallCntW-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]     loss_cnt_q, loss_cnt_d;
  logic [10:0]          sudi_q, sudi_d;

  logic comma;
  logic invalid;
  logic force_loss;
  logic bad_cg;
  logic loss_sat;

  assign comma      = is_comma(pudi);
  assign invalid    = is_invalid(pudi);
  assign force_loss = !power_on || !signal_detect;
  assign loss_sat   = (loss_cnt_q == {CNT_W{1'b1}});
  // In sync, a comma landing on an odd position is as bad as a coding error.
  assign bad_cg     = invalid || (comma && rx_even_q);

  always_comb begin
    state_d     = state_q;
    rx_even_d   = rx_even_q;
    comma_cnt_d = comma_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    good_cnt_d  = good_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    sudi_d      = sudi_q;

    if (force_loss) begin
      state_d     = StLossOfSync;
      comma_cnt_d = '0;
      bad_cnt_d   = '0;
      good_cnt_d  = '0;
      if ((state_q == StSyncAcquired) && !loss_sat) begin
        loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end else if (indicate) begin
      case (state_q)
        StLossOfSync: begin
          if (comma) begin
            rx_even_d   = 1'b1;
            comma_cnt_d = 3'd1;
            state_d     = StCommaDetect;
          end else begin
            rx_even_d = !rx_even_q;
          end
        end

        StCommaDetect: begin
          if (!invalid && !comma) begin
            rx_even_d = 1'b0;
            state_d   = StAcquireSync;
          end else begin
            rx_even_d = !rx_even_q;
            state_d   = StLossOfSync;
          end
        end

        StAcquireSync: begin
          if (!invalid && !comma) begin
            rx_even_d = !rx_even_q;
          end else if (comma && !invalid && !rx_even_q) begin
            rx_even_d = 1'b1;
            if (comma_cnt_q + 3'd1 == 3'(COMMA_ACQ)) begin
              state_d    = StSyncAcquired;
              bad_cnt_d  = '0;
              good_cnt_d = '0;
            end else begin
              comma_cnt_d = comma_cnt_q + 3'd1;
              state_d     = StCommaDetect;
            end
          end else begin
            rx_even_d = !rx_even_q;
            state_d   = StLossOfSync;
          end
        end

        default: begin
          rx_even_d = comma ? 1'b1 : !rx_even_q;
          if (bad_cg) begin
            good_cnt_d = '0;
            if (bad_cnt_q + 3'd1 == 3'(MAX_BAD)) begin
              state_d     = StLossOfSync;
              bad_cnt_d   = '0;
              comma_cnt_d = '0;
              if (!loss_sat) begin
                loss_cnt_d = loss_cnt_q + 1'b1;
              end
            end else begin
              bad_cnt_d = bad_cnt_q + 3'd1;
            end
          end else if (bad_cnt_q != '0) begin
            if (good_cnt_q + 3'd1 == 3'(GOOD_CGS)) begin
              bad_cnt_d  = bad_cnt_q - 3'd1;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 3'd1;
            end
          end
        end
      endcase
      sudi_d = {rx_even_d, pudi};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StLossOfSync;
      rx_even_q   <= 1'b0;
      comma_cnt_q <= '0;
      bad_cnt_q   <= '0;
      good_cnt_q  <= '0;
      loss_cnt_q  <= '0;
      sudi_q      <= '0;
    end else begin
      state_q     <= state_d;
      rx_even_q   <= rx_even_d;
      comma_cnt_q <= comma_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      good_cnt_q  <= good_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      sudi_q      <= sudi_d;
    end
  end

  assign code_sync_status = (state_q == StSyncAcquired);
  assign sudi             = sudi_q;
  assign sync_loss_cnt    = loss_cnt_q;

endmodule

// File: rtl/pcs_sync_lanes.sv
// Multi-lane 1000BASE-X code-group synchronization: independent per-lane sync
// FSMs with sliced buses and an aggregate all-lanes-in-sync flag.
module pcs_sync_lanes
  import pcs_sync_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned COMMA_ACQ = 3,
  parameter int unsigned GOOD_CGS  = 3,
  parameter int unsigned MAX_BAD   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       Clk,
  input  logic                       mr_main_reset,
  input  logic                       power_on,
  input  logic [NUM_LANES-1:0]       signal_detect,
  input  logic [NUM_LANES*10-1:0]    PUDI,
  input  logic [NUM_LANES-1:0]       PUDI_indicate,
  output logic [NUM_LANES-1:0]       code_sync_status,
  output logic [NUM_LANES*11-1:0]    SUDI,
  output logic                       all_sync,
  output logic [NUM_LANES*CNT_W-1:0] sync_loss_cnt
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pcs_sync_lane #(
      .COMMA_ACQ (COMMA_ACQ),
      .GOOD_CGS  (GOOD_CGS),
      .MAX_BAD   (MAX_BAD),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk              (Clk),
      .rst_n            (mr_main_reset),
      .power_on         (power_on),
      .signal_detect    (signal_detect[i]),
      .indicate         (PUDI_indicate[i]),
      .pudi             (PUDI[10*i +: 10]),
      .code_sync_status (code_sync_status[i]),
      .sudi             (SUDI[11*i +: 11]),
      .sync_loss_cnt    (sync_loss_cnt[CNT_W*i +: CNT_W])
    );
  end

  assign all_sync = &code_sync_status;

endmodule

// File: tb/tb_pcs_sync_lanes.sv
// Scoreboard bench for pcs_sync_lanes: the driver queues hand-computed SUDI/status/
// counter values per group and a negedge monitor compares them one cycle later.
module tb_pcs_sync_lanes;

  localparam int N  = 2;
  localparam int CW = 8;

  localparam logic [9:0] K   = 10'b0011111010;
  localparam logic [9:0] KN  = 10'b1100000101;
  localparam logic [9:0] D   = 10'b1001000101;
  localparam logic [9:0] BAD = 10'b1111111111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          power_on;
  logic [N-1:0]  sd;
  logic [N*10-1:0] pudi;
  logic [N-1:0]  ind;
  logic [N-1:0]  status;
  logic [N*11-1:0] sudi;
  logic          all_sync;
  logic [N*CW-1:0] loss_cnt;

  always #5 clk = ~clk;

  pcs_sync_lanes #(
    .NUM_LANES (N),
    .COMMA_ACQ (3),
    .GOOD_CGS  (3),
    .MAX_BAD   (4),
    .CNT_W     (CW)
  ) dut (
    .Clk              (clk),
    .mr_main_reset    (rst_n),
    .power_on         (power_on),
    .signal_detect    (sd),
    .PUDI             (pudi),
    .PUDI_indicate    (ind),
    .code_sync_status (status),
    .SUDI             (sudi),
    .all_sync         (all_sync),
    .sync_loss_cnt    (loss_cnt)
  );

  typedef struct packed {
    logic [10:0]   sudi;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [CW-1:0] exp_loss [N];
  logic [N-1:0]  ind_d = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lanes that acted at the last edge present a fresh SUDI one cycle later.
  always @(posedge clk) ind_d <= rst_n ? (ind & sd & {N{power_on}}) : '0;

  task automatic check_lane(input int l);
    exp_t e;
    if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL lane%0d_queue: output with no expected entry at %0t", l, $time);
    end else begin
      e = (l == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("lane%0d_sudi", l), 64'(sudi[l*11 +: 11]), 64'(e.sudi));
      chk($sformatf("lane%0d_status", l), 64'(status[l]), 64'(e.st));
      chk($sformatf("lane%0d_loss_cnt", l), 64'(loss_cnt[l*CW +: CW]), 64'(e.cnt));
    end
  endtask

  always @(negedge clk) begin
    if (ind_d[0]) check_lane(0);
    if (ind_d[1]) check_lane(1);
  end

  task automatic send(input int l, input logic [9:0] g, input logic rxe, input logic st);
    exp_t e;
    @(negedge clk);
    ind = '0;
    ind[l] = 1'b1;
    pudi[l*10 +: 10] = g;
    e.sudi = {rxe, g};
    e.st   = st;
    e.cnt  = exp_loss[l];
    if (l == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    ind = '0;
  endtask

  task automatic sync_lane(input int l);
    send(l, K, 1'b1, 1'b0);
    send(l, D, 1'b0, 1'b0);
    send(l, K, 1'b1, 1'b0);
    send(l, D, 1'b0, 1'b0);
    send(l, K, 1'b1, 1'b1);
  endtask

  // Drops signal_detect for one edge; a lane in sync counts one loss.
  task automatic force_lane(input int l);
    @(negedge clk);
    ind = '0;
    sd[l] = 1'b0;
    @(negedge clk);
    sd[l] = 1'b1;
    if (exp_loss[l] != 8'hFF) exp_loss[l] = exp_loss[l] + 1'b1;
  endtask

  task automatic check_zero(input string n);
    chk({n, "_status"}, 64'(status), 64'd0);
    chk({n, "_sudi"}, 64'(sudi), 64'd0);
    chk({n, "_all_sync"}, 64'(all_sync), 64'd0);
    chk({n, "_loss_cnt"}, 64'(loss_cnt), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ind = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_loss[0] = '0;
    exp_loss[1] = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    power_on = 1'b1;
    sd = '1;
    ind = '0;
    pudi = '0;
    exp_loss[0] = '0;
    exp_loss[1] = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Acquisition on lane0 after three aligned commas.
    sync_lane(0);
    idle();
    chk("t1_status", 64'(status), 64'b01);
    chk("t1_all_sync", 64'(all_sync), 64'd0);

    // Four invalid groups drop sync.
    send(0, BAD, 1'b0, 1'b1);
    send(0, BAD, 1'b1, 1'b1);
    send(0, BAD, 1'b0, 1'b1);
    exp_loss[0] = 8'd1;
    send(0, BAD, 1'b1, 1'b0);
    idle();
    chk("t2_status", 64'(status), 64'd0);

    // Bad groups interleaved with good ones never reach the drop threshold.
    sync_lane(0);
    send(0, BAD, 1'b0, 1'b1);
    send(0, D, 1'b1, 1'b1);
    send(0, D, 1'b0, 1'b1);
    send(0, D, 1'b1, 1'b1);
    send(0, BAD, 1'b0, 1'b1);
    send(0, D, 1'b1, 1'b1);
    send(0, D, 1'b0, 1'b1);
    send(0, D, 1'b1, 1'b1);
    send(0, BAD, 1'b0, 1'b1);
    send(0, BAD, 1'b1, 1'b1);
    idle();
    chk("t3_status", 64'(status), 64'b01);

    // Forced exit from sync counts, then a misaligned comma in ACQUIRE_SYNC.
    force_lane(0);
    chk("t4_force_status", 64'(status), 64'd0);
    chk("t4_force_cnt", 64'(loss_cnt[CW-1:0]), 64'd2);
    send(0, KN, 1'b1, 1'b0);
    send(0, D, 1'b0, 1'b0);
    send(0, D, 1'b1, 1'b0);
    send(0, K, 1'b0, 1'b0);
    idle();
    chk("t4_status", 64'(status), 64'd0);

    // Both lanes in sync, then lane1 loses signal_detect for one edge.
    do_reset();
    sync_lane(0);
    sync_lane(1);
    idle();
    chk("t5_status", 64'(status), 64'b11);
    chk("t5_all_sync", 64'(all_sync), 64'd1);
    force_lane(1);
    chk("t5_force_status", 64'(status), 64'b01);
    chk("t5_force_all_sync", 64'(all_sync), 64'd0);
    chk("t5_force_cnt", 64'(loss_cnt), {48'd0, 8'd1, 8'd0});
    sync_lane(1);
    idle();
    chk("t5_resync_all_sync", 64'(all_sync), 64'd1);

    // 256 forced losses saturate the counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      sync_lane(0);
      force_lane(0);
    end
    chk("t6_sat_cnt", 64'(loss_cnt[CW-1:0]), 64'd255);

    // Reset in the middle of acquisition clears everything.
    send(0, K, 1'b1, 1'b0);
    send(0, D, 1'b0, 1'b0);
    @(negedge clk);
    ind = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("t6_reset");
    rst_n = 1'b1;
    idle();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
